tmds_serializer_nch: RTL

TMDS_SERIALIZER_NCH -- requirements
Module: tmds_serializer_nch

---
 rtl/tmds_pkg.sv | 24 ++
 rtl/tmds_lane_shifter.sv | 34 +++
 rtl/tmds_serializer_nch.sv | 99 +++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS constants and helpers
package tmds_pkg;

  // Native TMDS symbol width
  localparam int TMDS_WORD_W = 10;

  // TMDS control-period symbols, indexed by {C1,C0}
  localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

  // Symbol inserted whenever the source fails to supply data in time
  localparam logic [TMDS_WORD_W-1:0] TMDS_IDLE_WORD = TMDS_CTRL_00;

  // Width of the underflow event counter
  localparam int UFLOW_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [UFLOW_CNT_W-1:0] sat_inc(input logic [UFLOW_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tmds_lane_shifter.sv
// rtl/tmds_lane_shifter.sv - one lane: parallel load, serial shift out
module tmds_lane_shifter
  import tmds_pkg::*;
#(
  parameter int                WORD_W    = 10,
  parameter int                MSB_FIRST = 0,
  parameter logic [WORD_W-1:0] IDLE_WORD = WORD_W'(TMDS_IDLE_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  output logic              serial
);

  logic [WORD_W-1:0] sh;

  // Load a fresh symbol at the symbol boundary, otherwise move the next bit into the output position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= IDLE_WORD;
    end else if (load) begin
      sh <= load_data;
    end else if (MSB_FIRST != 0) begin
      sh <= {sh[WORD_W-2:0], 1'b0};
    end else begin
      sh <= {1'b0, sh[WORD_W-1:1]};
    end
  end

  // Output bit is taken straight from a flop so every lane switches on the same edge
  assign serial = (MSB_FIRST != 0) ? sh[WORD_W-1] : sh[0];

endmodule

// File: rtl/tmds_serializer_nch.sv
// rtl/tmds_serializer_nch.sv - multi-lane TMDS serializer with idle insertion
module tmds_serializer_nch
  import tmds_pkg::*;
#(
  parameter int                NUM_CH    = 3,
  parameter int                WORD_W    = 10,
  parameter logic [WORD_W-1:0] IDLE_WORD = WORD_W'(TMDS_IDLE_WORD),
  parameter int                MSB_FIRST = 0
) (
  input  logic                     i_tmdsclk,
  input  logic                     i_reset_n,
  input  logic [NUM_CH*WORD_W-1:0] i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [NUM_CH-1:0]        o_serial,
  output logic                     o_clk_serial,
  output logic                     o_word_strobe,
  output logic                     o_underflow,
  input  logic                     i_clear_underflow,
  output logic [UFLOW_CNT_W-1:0]   o_underflow_cnt
);

  localparam int CNT_W = $clog2(WORD_W);

  if ((WORD_W % 2) != 0 || WORD_W < 4 || NUM_CH < 1) begin : g_param_check
    $error("tmds_serializer_nch: WORD_W must be even and >= 4, NUM_CH must be >= 1");
  end

  logic [CNT_W-1:0]         bit_cnt;
  logic                     full;
  logic                     armed;
  logic [NUM_CH*WORD_W-1:0] buf_q;
  logic [NUM_CH*WORD_W-1:0] load_data;
  logic                     load;
  logic                     xfer;

  assign load      = (bit_cnt == CNT_W'(WORD_W - 1));
  assign o_ready   = !full || load;
  assign xfer      = i_valid && o_ready;
  assign load_data = full ? buf_q : {NUM_CH{IDLE_WORD}};

  assign o_clk_serial  = (bit_cnt < CNT_W'(WORD_W / 2));
  assign o_word_strobe = (bit_cnt == '0);

  // Bit position within the current symbol period
  always_ff @(posedge i_tmdsclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bit_cnt <= '0;
    end else if (load) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Holding buffer: only a transfer writes it, so a full buffer ignores i_data
  always_ff @(posedge i_tmdsclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      buf_q <= '0;
      full  <= 1'b0;
      armed <= 1'b0;
    end else if (xfer) begin
      buf_q <= i_data;
      full  <= 1'b1;
      armed <= 1'b1;
    end else if (load) begin
      full  <= 1'b0;
    end
  end

  // Idle insertions after the first accepted word are underflows; a clear takes priority
  always_ff @(posedge i_tmdsclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_underflow     <= 1'b0;
      o_underflow_cnt <= '0;
    end else if (i_clear_underflow) begin
      o_underflow     <= 1'b0;
      o_underflow_cnt <= '0;
    end else if (load && !full && armed) begin
      o_underflow     <= 1'b1;
      o_underflow_cnt <= sat_inc(o_underflow_cnt);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    tmds_lane_shifter #(
      .WORD_W   (WORD_W),
      .MSB_FIRST(MSB_FIRST),
      .IDLE_WORD(IDLE_WORD)
    ) u_lane (
      .clk      (i_tmdsclk),
      .rst_n    (i_reset_n),
      .load     (load),
      .load_data(load_data[k*WORD_W +: WORD_W]),
      .serial   (o_serial[k])
    );
  end

endmodule
